seg7_decoder: RTL and testbench

- Hexadecimal-nibble to 7-segment display decoder for board-level display I/O.
- Provides two views of the same glyph:
  - a purely combinational segment vector, for glue logic and same-cycle use;
  - a registered segment vector, for driving pins glitch-free.
- After one clock edge the two views must agree.
- Sits between datapath/status logic and the LED display pins.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_decoder_if.sv | 25 ++
 rtl/seg7_comb.sv | 33 +++
 rtl/seg7_decoder.sv | 67 ++++++
 tb/tb_seg7_decoder.sv | 135 +++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment width, glyph table, blank pattern and encoder.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Glyphs for 0x0..0xF packed low-to-high, bit order g..a, active-high.
  localparam logic [16*SEG_W-1:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t seg7_encode(input logic [3:0] nibble, input logic blank);
    seg_t glyph;
    glyph = SEG_GLYPHS[nibble*SEG_W +: SEG_W];
    return blank ? SEG_BLANK : glyph;
  endfunction

endpackage

// File: rtl/seg7_decoder_if.sv
// Display-side bus of seg7_decoder; decimal point signals exist only with SEG7_DP_EN.
interface seg7_decoder_if;
  import seg7_pkg::*;

  logic       en;
  logic       blank;
  logic [3:0] digit;
  seg_t       seg_async;
  seg_t       seg_sync;
  logic       changed;
`ifdef SEG7_DP_EN
  logic       dp;
  logic       dp_sync;

  modport master (output en, blank, digit, dp,
                  input  seg_async, seg_sync, changed, dp_sync);
  modport slave  (input  en, blank, digit, dp,
                  output seg_async, seg_sync, changed, dp_sync);
`else
  modport master (output en, blank, digit,
                  input  seg_async, seg_sync, changed);
  modport slave  (input  en, blank, digit,
                  output seg_async, seg_sync, changed);
`endif
endinterface

// File: rtl/seg7_comb.sv
// Combinational nibble-to-segment encoder with output polarity applied.
// Optional decimal point path under SEG7_DP_EN.
module seg7_comb
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] i_digit,
  input  logic       i_blank,
`ifdef SEG7_DP_EN
  input  logic       i_dp,
  output logic       o_dp,
`endif
  output seg_t       o_seg
);

  seg_t w_seg_raw;

  always_comb begin
    w_seg_raw = seg7_encode(i_digit, i_blank);
    o_seg     = ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  end

`ifdef SEG7_DP_EN
  logic w_dp_raw;

  always_comb begin
    w_dp_raw = i_dp & ~i_blank;
    o_dp     = ACTIVE_LOW ? ~w_dp_raw : w_dp_raw;
  end
`endif

endmodule

// File: rtl/seg7_decoder.sv
// Hex-nibble 7-segment decoder: combinational and registered segment views plus change flag.
// Optional decimal point (input dp, output dp_sync) enabled by SEG7_DP_EN.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit RESET_BLANK = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seg7_decoder_if.slave bus
);

  // Reset pattern is chosen before polarity so both resets follow ACTIVE_LOW.
  localparam seg_t RST_RAW = RESET_BLANK ? SEG_BLANK : seg7_encode(4'h0, 1'b0);
  localparam seg_t RST_SEG = ACTIVE_LOW ? ~RST_RAW : RST_RAW;

  seg_t w_seg;
  seg_t r_seg_sync;
  logic r_changed;

`ifdef SEG7_DP_EN
  logic w_dp;
  logic r_dp_sync;

  seg7_comb #(.ACTIVE_LOW(ACTIVE_LOW)) u_comb (
    .i_digit (bus.digit),
    .i_blank (bus.blank),
    .i_dp    (bus.dp),
    .o_dp    (w_dp),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_sync <= ACTIVE_LOW;
    end else if (bus.en) begin
      r_dp_sync <= w_dp;
    end
  end

  assign bus.dp_sync = r_dp_sync;
`else
  seg7_comb #(.ACTIVE_LOW(ACTIVE_LOW)) u_comb (
    .i_digit (bus.digit),
    .i_blank (bus.blank),
    .o_seg   (w_seg)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_sync <= RST_SEG;
      r_changed  <= 1'b0;
    end else if (bus.en) begin
      r_seg_sync <= w_seg;
      r_changed  <= (w_seg != r_seg_sync);
    end else begin
      r_changed  <= 1'b0;
    end
  end

  assign bus.seg_async = w_seg;
  assign bus.seg_sync  = r_seg_sync;
  assign bus.changed   = r_changed;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed self-checking bench for seg7_decoder: default instance and an ACTIVE_LOW instance.
`timescale 1ns/1ps
module tb_seg7_decoder;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  seg7_decoder_if bus_hi ();
  seg7_decoder_if bus_lo ();

  seg7_decoder #(.ACTIVE_LOW(1'b0), .RESET_BLANK(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b1), .RESET_BLANK(1'b1)) u_dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo)
  );

  logic [6:0] exp_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_hi.en = 1'b1; bus_hi.blank = 1'b0; bus_hi.digit = 4'h8;
    bus_lo.en = 1'b1; bus_lo.blank = 1'b0; bus_lo.digit = 4'h8;
`ifdef SEG7_DP_EN
    bus_hi.dp = 1'b0;
    bus_lo.dp = 1'b0;
`endif

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    check("rst_seg_sync",  {1'b0, bus_hi.seg_sync},  8'h00);
    check("rst_changed",   {7'b0, bus_hi.changed},   8'h00);
    check("rst_seg_async", {1'b0, bus_hi.seg_async}, 8'h7F);
    check("al_rst_sync",   {1'b0, bus_lo.seg_sync},  8'h7F);
    check("al_rst_chg",    {7'b0, bus_lo.changed},   8'h00);

    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sync", {1'b0, bus_hi.seg_sync}, 8'h7F);
    check("post_rst_chg",  {7'b0, bus_hi.changed},  8'h01);

    // Sweep all nibbles; consecutive glyphs always differ
    for (int unsigned d = 0; d < 16; d++) begin
      bus_hi.digit = 4'(d);
      @(negedge clk);
      check($sformatf("sweep_async_%0h", d), {1'b0, bus_hi.seg_async}, {1'b0, exp_glyph[d]});
      check($sformatf("sweep_sync_%0h", d),  {1'b0, bus_hi.seg_sync},  {1'b0, exp_glyph[d]});
      check($sformatf("sweep_chg_%0h", d),   {7'b0, bus_hi.changed},   8'h01);
    end

    // Enable low holds the registered glyph
    bus_hi.digit = 4'h2;
    @(negedge clk);
    check("hold_load", {1'b0, bus_hi.seg_sync}, 8'h5B);
    bus_hi.en = 1'b0;
    bus_hi.digit = 4'h7;
    repeat (3) @(negedge clk);
    check("hold_sync",  {1'b0, bus_hi.seg_sync},  8'h5B);
    check("hold_chg",   {7'b0, bus_hi.changed},   8'h00);
    check("hold_async", {1'b0, bus_hi.seg_async}, 8'h07);

    // Blank forces off on both views
    bus_hi.en = 1'b1;
    bus_hi.digit = 4'hF;
    bus_hi.blank = 1'b1;
    #1;
    check("blank_async", {1'b0, bus_hi.seg_async}, 8'h00);
    @(negedge clk);
    check("blank_sync", {1'b0, bus_hi.seg_sync}, 8'h00);
    bus_hi.blank = 1'b0;
    @(negedge clk);
    check("unblank_sync", {1'b0, bus_hi.seg_sync}, 8'h71);
    check("unblank_chg",  {7'b0, bus_hi.changed},  8'h01);

    // Same value loaded repeatedly: changed only on the first edge
    bus_hi.digit = 4'h5;
    @(negedge clk);
    check("rep_sync_1", {1'b0, bus_hi.seg_sync}, 8'h6D);
    check("rep_chg_1",  {7'b0, bus_hi.changed},  8'h01);
    @(negedge clk);
    check("rep_chg_2",  {7'b0, bus_hi.changed},  8'h00);
    @(negedge clk);
    check("rep_chg_3",  {7'b0, bus_hi.changed},  8'h00);
    check("rep_sync_3", {1'b0, bus_hi.seg_sync}, 8'h6D);

    // Reset beats en and discards the pending value
    bus_hi.digit = 4'h3;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sync",  {1'b0, bus_hi.seg_sync},  8'h00);
    check("midrst_chg",   {7'b0, bus_hi.changed},   8'h00);
    check("midrst_async", {1'b0, bus_hi.seg_async}, 8'h4F);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_load", {1'b0, bus_hi.seg_sync}, 8'h4F);
    check("midrst_lchg", {7'b0, bus_hi.changed},  8'h01);

    // Inverted polarity instance
    bus_lo.digit = 4'h1;
    #1;
    check("al_async", {1'b0, bus_lo.seg_async}, 8'h79);
    @(negedge clk);
    check("al_sync", {1'b0, bus_lo.seg_sync}, 8'h79);
    bus_lo.blank = 1'b1;
    #1;
    check("al_blank_async", {1'b0, bus_lo.seg_async}, 8'h7F);
    @(negedge clk);
    check("al_blank_sync", {1'b0, bus_lo.seg_sync}, 8'h7F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
